step_counter: RTL and testbench
===============================

# step_counter

Parametrised up/down step counter: the registered, sequential successor to the team's 16-bit ripple incrementer. It holds a WIDTH-bit count that can be loaded, incremented or decremented by a run-time step, and it wraps or saturates at the boundaries. It also reports overflow/underflow and zero. Intended for program-counter, address-pointer and loop-count duties around the 8-bit ALU datapath.

## Interface
Parameters:
- WIDTH, 16, counter width in bits (≥2).
- SATURATE, 0, boundary mode: 0 = modulo-2^WIDTH wrap, 1 = clamp at 0 / 2^WIDTH−1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  load count from load_val this cycle.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- dir  input  1  0 = up (count + step), 1 = down (count − step).
- step  input  WIDTH  step magnitude, unsigned; 0 holds the value.
- count  output  WIDTH  current count, registered.
- zero  output  1  registered; high when count == 0.
- ovf  output  1  registered one-cycle pulse; boundary crossed by the last update.

## Operation
- Reset (async assert, any time): count = 0, zero = 1, ovf = 0. The reset value is held while rst is high. The first update happens on the first rising edge after rst deasserts.
- Priority per edge: load > en > hold.
- load = 1: count ← load_val, ovf ← 0, zero ← (load_val == 0). en, dir and step are ignored.
- load = 0, en = 1, dir = 0: compute sum = {1'b0,count} + {1'b0,step} at WIDTH+1 bits.
  - If carry = 1: ovf ← 1. count ← sum[WIDTH−1:0] when SATURATE = 0, else count ← all-ones.
  - If carry = 0: count ← sum, ovf ← 0.
- load = 0, en = 1, dir = 1: compute diff = {1'b0,count} − {1'b0,step} at WIDTH+1 bits.
  - If borrow (diff[WIDTH] = 1, i.e. step > count): ovf ← 1. count ← diff[WIDTH−1:0] when SATURATE = 0, else count ← 0.
  - Otherwise: count ← diff, ovf ← 0.
- en = 0 and load = 0: count holds, ovf ← 0.
- step = 0 with en = 1: count unchanged, ovf ← 0.
- Saturated count with a further step in the same direction: ovf pulses again on every such enabled edge; count stays at the rail.
- zero always reflects the count value registered on the same edge. It is never derived combinationally from the inputs.
- Arithmetic is a single WIDTH+1-bit add/subtract. No signed interpretation anywhere.

## Timing
- Latency 1 cycle: inputs sampled at edge N; count, zero and ovf are valid after edge N.
- ovf is high for exactly the one cycle following the offending update. Back-to-back offending updates give a continuously high ovf.
- No combinational path from any input to any output.
- rst asserted mid-operation: count, zero and ovf take their reset values immediately, without waiting for clk. A pending load or en is discarded.
- load and en both high: the load wins and no arithmetic is performed.

## Test plan
- Reset: assert rst mid-count (count = 16'h1234) between clock edges -> count = 0, zero = 1, ovf = 0 before the next edge; they stay there while rst is high.
- Up wrap (SATURATE = 0): load 16'hFFFE, then en = 1, dir = 0, step = 3 -> count = 16'h0001, ovf = 1 for one cycle. Next step of 1 -> count = 16'h0002, ovf = 0.
- Up saturate (SATURATE = 1): load 16'hFFF0, step = 16'h0020 twice -> count = 16'hFFFF both times, ovf high for two consecutive cycles.
- Down/underflow: load 5, dir = 1, step = 5 -> count = 0, zero = 1, ovf = 0. Step 1 again -> count = 16'hFFFF (wrap) or 0 (saturate), ovf = 1.
- Priority: load = 1, en = 1, load_val = 16'h00AA, step = 7 -> count = 16'h00AA, ovf = 0. Then en = 0 for 3 cycles -> count holds 16'h00AA.
- Width sweep: WIDTH = 8, load 8'hFF, step = 1 up -> count = 8'h00, zero = 1, ovf = 1.

Source files
------------

// File: rtl/step_counter.sv
// step_counter: registered up/down counter with a run-time step.
//
// Holds a WIDTH-bit count that can be loaded, or moved up/down by an unsigned
// step each enabled cycle. At the boundaries it either wraps modulo 2^WIDTH
// (SATURATE = 0) or clamps at 0 / all-ones (SATURATE = 1). All outputs are
// registered; nothing passes combinationally from inputs to outputs.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   SATURATE   0 = wrap, 1 = clamp at the rails
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_load      load o_count from i_load_val (wins over i_en)
//   i_load_val  value to load
//   i_en        count enable
//   i_dir       0 = up (count + step), 1 = down (count - step)
//   i_step      unsigned step magnitude; 0 holds the count
//   o_count     current count
//   o_zero      high when o_count == 0
//   o_ovf       one-cycle pulse: the last update crossed a boundary
module step_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_count;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_count_d;
  logic             w_ovf_d;

  // One extra bit holds carry (up) or borrow (down); both are plain unsigned.
  assign w_sum  = {1'b0, r_count} + {1'b0, i_step};
  assign w_diff = {1'b0, r_count} - {1'b0, i_step};

  always_comb begin
    w_count_d = r_count;
    w_ovf_d   = 1'b0;
    if (i_load) begin
      w_count_d = i_load_val;
    end else if (i_en) begin
      if (!i_dir) begin
        if (w_sum[WIDTH]) begin
          w_ovf_d   = 1'b1;
          w_count_d = SATURATE ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        end else begin
          w_count_d = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_diff[WIDTH]) begin
          w_ovf_d   = 1'b1;
          w_count_d = SATURATE ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
        end else begin
          w_count_d = w_diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      // Zero is registered from the next count so it always matches o_count.
      r_zero  <= (w_count_d == '0);
      r_ovf   <= w_ovf_d;
    end
  end

  assign o_count = r_count;
  assign o_zero  = r_zero;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: three instances (16-bit wrap, 16-bit saturate,
// 8-bit wrap) share one stimulus; the 8-bit one sees the low byte.
module tb_step_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        dir;
  logic [15:0] step;

  logic [15:0] cnt_w, cnt_s;
  logic [7:0]  cnt_8;
  logic        zero_w, zero_s, zero_8;
  logic        ovf_w, ovf_s, ovf_8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] c;
    logic        z;
    logic        o;
  } exp_t;

  exp_t   sb[$];
  longint m_cnt[3];

  always #5 clk = ~clk;

  step_counter #(.WIDTH(16), .SATURATE(1'b0)) u_w (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_load_val(load_val), .i_en(en),
    .i_dir(dir), .i_step(step), .o_count(cnt_w), .o_zero(zero_w), .o_ovf(ovf_w)
  );

  step_counter #(.WIDTH(16), .SATURATE(1'b1)) u_s (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_load_val(load_val), .i_en(en),
    .i_dir(dir), .i_step(step), .o_count(cnt_s), .o_zero(zero_s), .o_ovf(ovf_s)
  );

  step_counter #(.WIDTH(8), .SATURATE(1'b0)) u_8 (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_load_val(load_val[7:0]), .i_en(en),
    .i_dir(dir), .i_step(step[7:0]), .o_count(cnt_8), .o_zero(zero_8), .o_ovf(ovf_8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in integer terms: range checks instead of carry bits.
  function automatic void model(input int w, input bit sat, input longint c, input bit ld,
                                input longint lv, input bit e, input bit d, input longint st,
                                output longint nc, output bit no);
    longint mx = (longint'(1) << w) - 1;
    lv &= mx;
    st &= mx;
    nc = c;
    no = 1'b0;
    if (ld) begin
      nc = lv;
    end else if (e && !d) begin
      if (c + st > mx) begin
        no = 1'b1;
        nc = sat ? mx : ((c + st) & mx);
      end else begin
        nc = c + st;
      end
    end else if (e && d) begin
      if (st > c) begin
        no = 1'b1;
        nc = sat ? 0 : ((c - st) & mx);
      end else begin
        nc = c - st;
      end
    end
  endfunction

  function automatic logic [33:0] observe(input int i);
    case (i)
      0:       return {ovf_w, zero_w, 16'h0, cnt_w};
      1:       return {ovf_s, zero_s, 16'h0, cnt_s};
      default: return {ovf_8, zero_8, 24'h0, cnt_8};
    endcase
  endfunction

  task automatic op(input string tag, input bit ld, input logic [15:0] lv, input bit e,
                    input bit d, input logic [15:0] st);
    longint nc;
    bit     no;
    exp_t   x;
    logic [33:0] ob;
    load = ld; load_val = lv; en = e; dir = d; step = st;
    for (int i = 0; i < 3; i++) begin
      model((i == 2) ? 8 : 16, (i == 1), m_cnt[i], ld, longint'(lv), e, d, longint'(st),
            nc, no);
      m_cnt[i] = nc;
      x.c = 32'(nc);
      x.z = (nc == 0);
      x.o = no;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL %s/u%0d observed=no-entry expected=scoreboard-entry", tag, i);
      end else begin
        tests--;
        x  = sb.pop_front();
        ob = observe(i);
        chk($sformatf("%s/u%0d_cnt", tag, i), ob[31:0], x.c);
        chk($sformatf("%s/u%0d_zero", tag, i), {31'h0, ob[32]}, {31'h0, x.z});
        chk($sformatf("%s/u%0d_ovf", tag, i), {31'h0, ob[33]}, {31'h0, x.o});
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cw"}, {16'h0, cnt_w}, 32'h0);
    chk({tag, "_cs"}, {16'h0, cnt_s}, 32'h0);
    chk({tag, "_c8"}, {24'h0, cnt_8}, 32'h0);
    chk({tag, "_z"}, {29'h0, zero_w, zero_s, zero_8}, 32'h7);
    chk({tag, "_o"}, {29'h0, ovf_w, ovf_s, ovf_8}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b0; step = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    #12;
    chk_reset("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset mid-count, with a pending load that must be discarded.
    op("ld_1234", 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_cw", {16'h0, cnt_w}, 32'h1234);
    #3;
    rst = 1'b1; load = 1'b1; load_val = 16'h5555; en = 1'b1; step = 16'h1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset("rst_held");
    rst = 1'b0; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    sb.delete();

    // Up wrap / saturate.
    op("ld_fffe", 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0);
    op("up3", 1'b0, 16'h0, 1'b1, 1'b0, 16'h3);
    chk("up3_wrap", {15'h0, ovf_w, cnt_w}, {15'h0, 1'b1, 16'h0001});
    chk("up3_sat", {15'h0, ovf_s, cnt_s}, {15'h0, 1'b1, 16'hFFFF});
    op("up1", 1'b0, 16'h0, 1'b1, 1'b0, 16'h1);
    chk("up1_wrap", {15'h0, ovf_w, cnt_w}, {15'h0, 1'b0, 16'h0002});
    chk("up1_sat_rail", {15'h0, ovf_s, cnt_s}, {15'h0, 1'b1, 16'hFFFF});

    op("ld_fff0", 1'b1, 16'hFFF0, 1'b0, 1'b0, 16'h0);
    op("up20a", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020);
    chk("up20a_sat", {15'h0, ovf_s, cnt_s}, {15'h0, 1'b1, 16'hFFFF});
    op("up20b", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020);
    chk("up20b_sat", {15'h0, ovf_s, cnt_s}, {15'h0, 1'b1, 16'hFFFF});

    // Down to zero, then underflow.
    op("ld_5", 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0);
    op("dn5", 1'b0, 16'h0, 1'b1, 1'b1, 16'h5);
    chk("dn5_wrap", {14'h0, zero_w, ovf_w, cnt_w}, {14'h0, 1'b1, 1'b0, 16'h0});
    op("dn1", 1'b0, 16'h0, 1'b1, 1'b1, 16'h1);
    chk("dn1_wrap", {14'h0, zero_w, ovf_w, cnt_w}, {14'h0, 1'b0, 1'b1, 16'hFFFF});
    chk("dn1_sat", {14'h0, zero_s, ovf_s, cnt_s}, {14'h0, 1'b1, 1'b1, 16'h0});

    // Load beats enable; then hold.
    op("ld_en", 1'b1, 16'h00AA, 1'b1, 1'b0, 16'h7);
    chk("ld_en_cw", {15'h0, ovf_w, cnt_w}, {15'h0, 1'b0, 16'h00AA});
    for (int k = 0; k < 3; k++) begin
      op($sformatf("hold%0d", k), 1'b0, 16'h0, 1'b0, 1'b0, 16'h7);
      chk($sformatf("hold%0d_cw", k), {16'h0, cnt_w}, 32'h00AA);
    end
    op("step0", 1'b0, 16'h0, 1'b1, 1'b1, 16'h0);
    chk("step0_cw", {15'h0, ovf_w, cnt_w}, {15'h0, 1'b0, 16'h00AA});

    // 8-bit instance wrapping from all-ones.
    op("ld_ff", 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    op("w8_up1", 1'b0, 16'h0, 1'b1, 1'b0, 16'h1);
    chk("w8_up1", {22'h0, zero_8, ovf_8, cnt_8}, {22'h0, 1'b1, 1'b1, 8'h00});

    // Mixed random traffic, checked through the scoreboard.
    for (int k = 0; k < 40; k++) begin
      op($sformatf("rnd%0d", k), ($urandom_range(0, 7) == 0), 16'($urandom),
         ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 3) == 0 ?
         $urandom : $urandom_range(0, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
